// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock,
// start/done handshake, divide-by-zero detection, back-to-back capable.
module seq_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc;        // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] dvsr;
    logic [WIDTH-1:0] prem;       // partial remainder, low WIDTH bits
    logic [WIDTH:0]   p_shift;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] prem_next;

    // The stored partial remainder is always below the divisor, so its bit
    // WIDTH is zero between steps; only the shifted/trial values need WIDTH+1.
    // NOTE: every signal assigned in always_comb gets a value on every path,
    // otherwise synthesis infers a latch.
    always_comb begin
        p_shift   = {prem, acc[WIDTH-1]};
        trial     = p_shift - {1'b0, dvsr};
        acc_next  = {acc[WIDTH-2:0], ~trial[WIDTH]};
        prem_next = trial[WIDTH] ? p_shift[WIDTH-1:0] : trial[WIDTH-1:0];
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the operand/working registers are reset too; they are
            // few flops and a known state simplifies debug after abort.
            state       <= IDLE;
            cnt         <= '0;
            acc         <= '0;
            dvsr        <= '0;
            prem        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        acc  <= dividend;
                        dvsr <= divisor;
                        if (divisor == '0) begin
                            state       <= DONE;
                            done        <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                            cnt   <= '0;
                            prem  <= '0;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc  <= acc_next;
                    prem <= prem_next;
                    cnt  <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        state       <= DONE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        quotient    <= acc_next;
                        remainder   <= prem_next;
                        div_by_zero <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed WIDTH=16 scenarios plus a WIDTH=32 random
// regression, checked every cycle against a transaction-level model.
module tb_seq_divider;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;

    logic        start16 = 1'b0;
    logic [15:0] dividend16 = '0, divisor16 = '0;
    logic        busy16, done16, dbz16;
    logic [15:0] q16, r16;

    logic        start32 = 1'b0;
    logic [31:0] dividend32 = '0, divisor32 = '0;
    logic        busy32, done32, dbz32;
    logic [31:0] q32, r32;

    seq_divider #(.WIDTH(16)) u_div16 (
        .clk(clk), .rst_n(rst_n), .start(start16),
        .dividend(dividend16), .divisor(divisor16),
        .busy(busy16), .done(done16), .quotient(q16),
        .remainder(r16), .div_by_zero(dbz16)
    );

    seq_divider #(.WIDTH(32)) u_div32 (
        .clk(clk), .rst_n(rst_n), .start(start32),
        .dividend(dividend32), .divisor(divisor32),
        .busy(busy32), .done(done32), .quotient(q32),
        .remainder(r32), .div_by_zero(dbz32)
    );

    int vectors = 0;
    int errors  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: an accepted start books WIDTH busy cycles and the
    // arithmetic answer; the answer appears with done when the cycles run out.
    typedef struct packed {
        logic [7:0]  left;
        logic        busy;
        logic        done;
        logic        dbz;
        logic [63:0] q;
        logic [63:0] r;
        logic [63:0] pq;
        logic [63:0] pr;
    } model_t;

    model_t m16 = '0;
    model_t m32 = '0;

    function automatic model_t model_next(model_t m, logic st, logic [63:0] dd,
                                          logic [63:0] dv, int w);
        model_t n = m;
        n.done = 1'b0;
        if (m.busy) begin
            n.left = m.left - 8'd1;
            if (n.left == 8'd0) begin
                n.busy = 1'b0;
                n.done = 1'b1;
                n.q    = m.pq;
                n.r    = m.pr;
                n.dbz  = 1'b0;
            end
        end else if (st) begin
            if (dv == 64'd0) begin
                n.done = 1'b1;
                n.q    = (64'd1 << w) - 64'd1;
                n.r    = dd;
                n.dbz  = 1'b1;
            end else begin
                n.busy = 1'b1;
                n.left = 8'(w);
                n.pq   = dd / dv;
                n.pr   = dd % dv;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m16 <= '0;
            m32 <= '0;
        end else begin
            m16 <= model_next(m16, start16, 64'(dividend16), 64'(divisor16), 16);
            m32 <= model_next(m32, start32, 64'(dividend32), 64'(divisor32), 32);
        end
    end

    always begin
        @(posedge clk);
        #1;
        check("busy16", 64'(busy16), 64'(m16.busy));
        check("done16", 64'(done16), 64'(m16.done));
        check("quot16", 64'(q16),    m16.q);
        check("rem16",  64'(r16),    m16.r);
        check("dbz16",  64'(dbz16),  64'(m16.dbz));
        check("busy32", 64'(busy32), 64'(m32.busy));
        check("done32", 64'(done32), 64'(m32.done));
        check("quot32", 64'(q32),    m32.q);
        check("rem32",  64'(r32),    m32.r);
        check("dbz32",  64'(dbz32),  64'(m32.dbz));
    end

    // One start pulse; returns busy cycles seen and negedges until done
    // (a WIDTH=16 operation completes on the 17th, divide-by-zero on the 1st).
    task automatic run16(input logic [15:0] dd, input logic [15:0] dv,
                         output int busy_cnt, output int wait_cnt);
        @(negedge clk);
        start16    = 1'b1;
        dividend16 = dd;
        divisor16  = dv;
        @(negedge clk);
        start16  = 1'b0;
        busy_cnt = 0;
        wait_cnt = 1;
        while (!done16 && wait_cnt < 40) begin
            if (busy16) busy_cnt++;
            @(negedge clk);
            wait_cnt++;
        end
        check("done16_seen", 64'(done16), 64'd1);
    endtask

    initial begin
        int bc, wc, n, dcount;
        logic [31:0] a, b;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy16), 64'd0);
        check("rst_done", 64'(done16), 64'd0);
        check("rst_quot", 64'(q16),    64'd0);
        check("rst_rem",  64'(r16),    64'd0);
        check("rst_dbz",  64'(dbz16),  64'd0);
        rst_n = 1'b1;

        run16(16'd100, 16'd7, bc, wc);
        check("t1_busy_cycles", 64'(bc),  64'd16);
        check("t1_latency",     64'(wc),  64'd17);
        check("t1_quot",        64'(q16), 64'd14);
        check("t1_rem",         64'(r16), 64'd2);
        check("t1_dbz",         64'(dbz16), 64'd0);

        run16(16'hFFFF, 16'hFFFF, bc, wc);
        check("t2a_quot", 64'(q16), 64'd1);
        check("t2a_rem",  64'(r16), 64'd0);
        run16(16'h8000, 16'h8001, bc, wc);
        check("t2b_quot", 64'(q16), 64'd0);
        check("t2b_rem",  64'(r16), 64'h8000);

        run16(16'd1234, 16'd0, bc, wc);
        check("t3_busy_cycles", 64'(bc),    64'd0);
        check("t3_latency",     64'(wc),    64'd1);
        check("t3_quot",        64'(q16),   64'hFFFF);
        check("t3_rem",         64'(r16),   64'd1234);
        check("t3_dbz",         64'(dbz16), 64'd1);

        // start held high, operands changed while running
        @(negedge clk);
        start16    = 1'b1;
        dividend16 = 16'd50;
        divisor16  = 16'd5;
        @(negedge clk);
        dividend16 = 16'hFFFF;
        divisor16  = 16'd1;
        n = 0;
        while (!done16 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("t4a_done", 64'(done16), 64'd1);
        check("t4a_quot", 64'(q16),    64'd10);
        check("t4a_rem",  64'(r16),    64'd0);
        @(negedge clk);
        check("t4_busy_after_done", 64'(busy16), 64'd1);
        start16 = 1'b0;
        bc = 0;
        n  = 0;
        while (!done16 && n < 40) begin
            if (busy16) bc++;
            @(negedge clk);
            n++;
        end
        check("t4b_done",        64'(done16), 64'd1);
        check("t4b_busy_cycles", 64'(bc),     64'd16);
        check("t4b_quot",        64'(q16),    64'hFFFF);
        check("t4b_rem",         64'(r16),    64'd0);

        // reset in the middle of a run
        @(negedge clk);
        start16    = 1'b1;
        dividend16 = 16'd1000;
        divisor16  = 16'd3;
        @(negedge clk);
        start16 = 1'b0;
        repeat (7) @(negedge clk);
        check("t5_busy_before_rst", 64'(busy16), 64'd1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_busy", 64'(busy16), 64'd0);
        check("t5_rst_done", 64'(done16), 64'd0);
        check("t5_rst_quot", 64'(q16),    64'd0);
        check("t5_rst_rem",  64'(r16),    64'd0);
        check("t5_rst_dbz",  64'(dbz16),  64'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        dcount = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done16 || busy16) dcount++;
        end
        check("t5_no_activity", 64'(dcount), 64'd0);
        run16(16'd9, 16'd4, bc, wc);
        check("t5_quot", 64'(q16), 64'd2);
        check("t5_rem",  64'(r16), 64'd1);

        // WIDTH=32 regression
        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            case (i % 10)
                0: b = 32'd1;
                1: begin
                    a = $urandom >> 1;
                    b = a + 32'($urandom_range(1, 1000));
                end
                default: begin
                    b = $urandom >> $urandom_range(0, 31);
                    if (b == 32'd0) b = 32'd1;
                end
            endcase
            if (i == 3) begin
                a = 32'hFFFF_FFFF;
                b = 32'h8000_0001;
            end
            if (i == 502) b = 32'd0;
            @(negedge clk);
            start32    = 1'b1;
            dividend32 = a;
            divisor32  = b;
            @(negedge clk);
            start32 = 1'b0;
            n = 0;
            while (!done32 && n < 40) begin
                @(negedge clk);
                n++;
            end
            check("r32_done_seen", 64'(done32), 64'd1);
            if (i == 3) begin
                check("r32_msb_quot", 64'(q32), 64'd1);
                check("r32_msb_rem",  64'(r32), 64'h7FFF_FFFE);
            end
        end

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
